es1_spu_mac_unit: RTL and testbench



---
 rtl/es1_spu_mac_unit.sv | 139 +++++++++++++
 tb/tb_es1_spu_mac_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/es1_spu_mac_unit.sv
// Signed multiply-accumulate for the ES1 SPU datapath: register inputs, multiply, accumulate, then optional delay.
// Optional MAC_SATURATE_EN: clamp set/add/sub results to the signed M_DATA_BITS range instead of wrapping.
module es1_spu_mac_unit #(
    parameter int    LATENCY         = 3,
    parameter int    S_DATA0_BITS    = 32,
    parameter int    S_DATA1_BITS    = 32,
    parameter int    M_DATA_BITS     = 32,
    parameter bit    IMMEDIATE_DATA0 = 1'b0,
    parameter bit    IMMEDIATE_DATA1 = 1'b0,
    parameter string DEVICE          = "RTL",
    parameter string SIMULATION      = "false",
    parameter string DEBUG           = "false"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cke,
    input  logic                    s_set,
    input  logic                    s_sub,
    input  logic [S_DATA0_BITS-1:0] s_data0,
    input  logic [S_DATA1_BITS-1:0] s_data1,
    input  logic                    s_valid,
    output logic [M_DATA_BITS-1:0]  m_data
);

    localparam int PROD_BITS = S_DATA0_BITS + S_DATA1_BITS;
    localparam int EXT_BITS  = ((M_DATA_BITS > PROD_BITS) ? M_DATA_BITS : PROD_BITS) + 2;
    // DSP mapping and debug builds keep the operand registers even for constant operands.
    localparam bit KEEP_REG0 = !IMMEDIATE_DATA0 || (DEVICE == "ULTRASCALE_PLUS") || (DEBUG == "true");
    localparam bit KEEP_REG1 = !IMMEDIATE_DATA1 || (DEVICE == "ULTRASCALE_PLUS") || (DEBUG == "true");

    logic signed [S_DATA0_BITS-1:0] st1_data0;
    logic signed [S_DATA1_BITS-1:0] st1_data1;
    logic                           st1_valid, st1_set, st1_sub;
    logic signed [PROD_BITS-1:0]    st2_prod;
    logic                           st2_valid, st2_set, st2_sub;
    logic signed [M_DATA_BITS-1:0]  acc, acc_next;
    logic signed [EXT_BITS-1:0]     acc_ext, prod_ext, sum_ext;

    // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st1_valid <= 1'b0;
            st1_set   <= 1'b0;
            st1_sub   <= 1'b0;
        end else if (cke) begin
            st1_valid <= s_valid;
            st1_set   <= s_set;
            st1_sub   <= s_sub;
        end
    end

    if (KEEP_REG0) begin : g_reg0
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)   st1_data0 <= '0;
            else if (cke) st1_data0 <= s_data0;
        end
    end else begin : g_imm0
        assign st1_data0 = s_data0;
    end

    if (KEEP_REG1) begin : g_reg1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)   st1_data1 <= '0;
            else if (cke) st1_data1 <= s_data1;
        end
    end else begin : g_imm1
        assign st1_data1 = s_data1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st2_prod  <= '0;
            st2_valid <= 1'b0;
            st2_set   <= 1'b0;
            st2_sub   <= 1'b0;
        end else if (cke) begin
            st2_prod  <= st1_data0 * st1_data1;
            st2_valid <= st1_valid;
            st2_set   <= st1_set;
            st2_sub   <= st1_sub;
        end
    end

    // Full-precision sum so saturation sees the true result, not a wrapped one.
    assign acc_ext  = {{(EXT_BITS-M_DATA_BITS){acc[M_DATA_BITS-1]}}, acc};
    assign prod_ext = {{(EXT_BITS-PROD_BITS){st2_prod[PROD_BITS-1]}}, st2_prod};

    always_comb begin
        // NOTE: default assigned first so every path drives sum_ext and no latch is inferred.
        sum_ext = acc_ext + prod_ext;
        if (st2_set)      sum_ext = prod_ext;
        else if (st2_sub) sum_ext = acc_ext - prod_ext;
    end

`ifdef MAC_SATURATE_EN
    localparam logic signed [EXT_BITS-1:0] SAT_MAX = {{(EXT_BITS-M_DATA_BITS+1){1'b0}}, {(M_DATA_BITS-1){1'b1}}};
    localparam logic signed [EXT_BITS-1:0] SAT_MIN = {{(EXT_BITS-M_DATA_BITS+1){1'b1}}, {(M_DATA_BITS-1){1'b0}}};

    always_comb begin
        acc_next = sum_ext[M_DATA_BITS-1:0];
        if (sum_ext > SAT_MAX)      acc_next = SAT_MAX[M_DATA_BITS-1:0];
        else if (sum_ext < SAT_MIN) acc_next = SAT_MIN[M_DATA_BITS-1:0];
    end
`else
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum_ext[EXT_BITS-1:M_DATA_BITS];
    assign acc_next      = sum_ext[M_DATA_BITS-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  acc <= '0;
        else if (cke && st2_valid)   acc <= acc_next;
    end

    if (LATENCY == 3) begin : g_no_delay
        assign m_data = acc;
    end else begin : g_delay
        logic [M_DATA_BITS-1:0] dly [LATENCY-3];

        // NOTE: the delay line is reset element by element so in-flight results are discarded on reset.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < LATENCY-3; i++) dly[i] <= '0;
            end else if (cke) begin
                dly[0] <= acc;
                for (int i = 1; i < LATENCY-3; i++) dly[i] <= dly[i-1];
            end
        end

        assign m_data = dly[LATENCY-4];
    end

    if (SIMULATION == "true") begin : g_sim_checks
        always_ff @(posedge clk) begin
            if (reset && cke) assert (!$isunknown({s_valid, s_set, s_sub}));
        end
    end

endmodule

// File: tb/tb_es1_spu_mac_unit.sv
// Self-checking bench for es1_spu_mac_unit: three configurations against a queue-free arithmetic reference model.
module tb_es1_spu_mac_unit;

    logic clk = 1'b0, reset = 1'b0, cke = 1'b0;
    logic s_set = 1'b0, s_sub = 1'b0, s_valid = 1'b0;

    logic signed [7:0]  a_d0 = '0;  logic signed [8:0]  a_d1 = '0;  logic signed [9:0]  a_m;
    logic signed [31:0] b_d0 = '0;  logic signed [15:0] b_d1 = '0;  logic signed [7:0]  b_m;
    logic signed [63:0] c_d0 = '0;  logic signed [31:0] c_d1 = '0;  logic signed [63:0] c_m;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    es1_spu_mac_unit #(.LATENCY(3), .S_DATA0_BITS(8), .S_DATA1_BITS(9), .M_DATA_BITS(10)) u_a (
        .clk(clk), .reset(reset), .cke(cke), .s_set(s_set), .s_sub(s_sub),
        .s_data0(a_d0), .s_data1(a_d1), .s_valid(s_valid), .m_data(a_m));
    es1_spu_mac_unit #(.LATENCY(4), .S_DATA0_BITS(32), .S_DATA1_BITS(16), .M_DATA_BITS(8)) u_b (
        .clk(clk), .reset(reset), .cke(cke), .s_set(s_set), .s_sub(s_sub),
        .s_data0(b_d0), .s_data1(b_d1), .s_valid(s_valid), .m_data(b_m));
    es1_spu_mac_unit #(.LATENCY(4), .S_DATA0_BITS(64), .S_DATA1_BITS(32), .M_DATA_BITS(64)) u_c (
        .clk(clk), .reset(reset), .cke(cke), .s_set(s_set), .s_sub(s_sub),
        .s_data0(c_d0), .s_data1(c_d1), .s_valid(s_valid), .m_data(c_m));

    // Reference model: accumulator value after each enabled edge, looked up LATENCY-1 edges later.
    logic signed [127:0] acc_m [3];
    logic signed [127:0] exp_m [3];
    logic signed [127:0] hist  [3][0:2047];
    int edges = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : 4;
    endfunction

    function automatic int mbits_of(input int d);
        return (d == 0) ? 10 : ((d == 1) ? 8 : 64);
    endfunction

    function automatic logic signed [127:0] mac_ref(input logic signed [127:0] acc,
                                                   input logic signed [127:0] prod,
                                                   input logic set, input logic sub,
                                                   input logic valid, input int mbits);
        logic signed [127:0] r;
        if (!valid) return acc;
        r = set ? prod : (sub ? acc - prod : acc + prod);
`ifdef MAC_SATURATE_EN
        begin
            logic signed [127:0] hi, lo;
            hi = (128'sd1 <<< (mbits-1)) - 128'sd1;
            lo = -(128'sd1 <<< (mbits-1));
            if (r > hi)      r = hi;
            else if (r < lo) r = lo;
        end
`else
        r = (r <<< (128-mbits)) >>> (128-mbits);
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic signed [127:0] got, input logic signed [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        edges = 0;
        for (int d = 0; d < 3; d++) begin
            acc_m[d] = '0;
            exp_m[d] = '0;
        end
    endtask

    task automatic model_edge();
        logic signed [127:0] x0, x1;
        logic signed [127:0] prod [3];
        int k;
        x0 = a_d0; x1 = a_d1; prod[0] = x0 * x1;
        x0 = b_d0; x1 = b_d1; prod[1] = x0 * x1;
        x0 = c_d0; x1 = c_d1; prod[2] = x0 * x1;
        for (int d = 0; d < 3; d++) begin
            acc_m[d] = mac_ref(acc_m[d], prod[d], s_set, s_sub, s_valid, mbits_of(d));
            hist[d][edges] = acc_m[d];
            k = edges - (lat_of(d) - 1);
            exp_m[d] = (k >= 0) ? hist[d][k] : '0;
        end
        edges++;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset && cke) model_edge();
        #1;
        check("model_a", a_m, exp_m[0]);
        check("model_b", b_m, exp_m[1]);
        check("model_c", c_m, exp_m[2]);
    endtask

    int dir_set[14], dir_sub[14], dir_val[14], dir_cke[14];
    int dir_d0[14], dir_d1[14], dir_exp_a[14];
    int b_dir0[3], b_dir1[3], b_lit[3];

    initial begin
        dir_set   = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        dir_sub   = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        dir_val   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        dir_cke   = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        dir_d0    = '{2, 3, 1, 0, 3, 2, -2, 5, 4, 99, 4, -9, 0, 0};
        dir_d1    = '{3, 4, 2, 3, 3, 2, 3, 5, -2, 88, 2, 3, 0, 0};
        dir_exp_a = '{0, 0, 6, 18, 16, 16, 9, 9, 13, 7, -1, -1, -9, 18};
        b_dir0    = '{100, 100, 127};
        b_dir1    = '{1, 1, 2};
`ifdef MAC_SATURATE_EN
        b_lit     = '{100, 127, -127};
`else
        b_lit     = '{100, -56, -54};
`endif
        model_reset();

        // Reset held with the clock enabled: every output stays 0.
        cke = 1'b1;
        repeat (3) cycle();
        check("reset_a", a_m, 0);
        check("reset_b", b_m, 0);
        check("reset_c", c_m, 0);
        reset = 1'b1;

        // Directed sequence, including a stalled cycle and an invalid beat.
        for (int i = 0; i < 14; i++) begin
            cke     = (dir_cke[i] != 0);
            s_valid = (dir_val[i] != 0);
            s_set   = (dir_set[i] != 0);
            s_sub   = (dir_sub[i] != 0);
            a_d0    = 8'(dir_d0[i]);
            a_d1    = 9'(dir_d1[i]);
            b_d0    = (i < 3) ? 32'(b_dir0[i]) : 32'($urandom);
            b_d1    = (i < 3) ? 16'(b_dir1[i]) : 16'($urandom);
            c_d0    = {$urandom, $urandom};
            c_d1    = $urandom;
            cycle();
            check("dir_a", a_m, dir_exp_a[i]);
            if (i >= 3 && i <= 5) check("dir_b", b_m, b_lit[i-3]);
        end

        // Randomized beats with random stalls, mixing small and full-range operands.
        for (int i = 0; i < 400; i++) begin
            cke     = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 4) != 0);
            s_set   = ($urandom_range(0, 6) == 0);
            s_sub   = ($urandom_range(0, 1) == 1);
            a_d0    = 8'($urandom);
            a_d1    = 9'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                b_d0 = 32'($urandom_range(0, 255)) - 32'd128;
                b_d1 = 16'($urandom_range(0, 7)) - 16'd3;
                c_d0 = 64'($urandom_range(0, 255)) - 64'd128;
            end else begin
                b_d0 = $urandom;
                b_d1 = 16'($urandom);
                c_d0 = {$urandom, $urandom};
            end
            c_d1 = $urandom;
            cycle();
        end

        // Beats in flight, then an asynchronous reset between edges.
        cke = 1'b1;
        s_valid = 1'b1;
        s_set = 1'b1;
        s_sub = 1'b0;
        a_d0 = 8'sd11; a_d1 = 9'sd5;
        b_d0 = 32'sd3; b_d1 = 16'sd3;
        c_d0 = 64'sd1000; c_d1 = 32'sd1000;
        repeat (2) cycle();
        reset = 1'b0;
        #1;
        check("async_reset_a", a_m, 0);
        check("async_reset_b", b_m, 0);
        check("async_reset_c", c_m, 0);
        model_reset();
        repeat (2) cycle();
        reset = 1'b1;

        // First beat after reset without set accumulates onto 0.
        s_set = 1'b0;
        a_d0 = 8'sd7;  a_d1 = 9'sd7;
        b_d0 = 32'sd7; b_d1 = 16'sd7;
        c_d0 = 64'sd7; c_d1 = 32'sd7;
        cycle();
        s_valid = 1'b0;
        cycle();
        cycle();
        check("post_reset_a", a_m, 49);
        cycle();
        check("post_reset_b", b_m, 49);
        check("post_reset_c", c_m, 49);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
